// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the round-robin tri-state bus arbiter: FSM encoding,
// sizing helpers and the owner-index width macro.
`define TBA_OWNER_W(n) (((n) > 1) ? tristate_bus_arbiter_pkg::tba_clog2(n) : 1)

package tristate_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_TURN  = 2'b10
    } state_e;

    function automatic int tba_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'(1) << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    function automatic int tba_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first requesting source at or above the
// pointer, wrapping from N_SRC-1 back to 0.
module tristate_bus_arbiter_rr_priority_picker #(
    parameter int N_SRC = 4,
    parameter int OW    = 2
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [OW-1:0]    ptr_i,
    output logic [OW-1:0]    winner_o,
    output logic             any_req_o
);

    logic [N_SRC-1:0] rot;
    int               idx;

    always_comb begin
        // Rotate so the pointer position lands on bit 0; lowest set bit wins.
        rot       = (req_i >> ptr_i) | (req_i << (N_SRC - int'(ptr_i)));
        idx       = 0;
        winner_o  = '0;
        any_req_o = |req_i;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (rot[j]) begin
                idx = int'(ptr_i) + j;
                if (idx >= N_SRC) idx = idx - N_SRC;
                winner_o = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter that registers the winning source word, drives it onto a
// shared tri-state bus for HOLD_CYCLES, then floats the bus for TURN_CYCLES.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int N_SRC       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 1,
    localparam int OW         = `TBA_OWNER_W(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*WIDTH-1:0] data_in,
    output logic [N_SRC-1:0]       grant,
    output wire  [WIDTH-1:0]       bus,
    output logic                   bus_valid,
    output logic [OW-1:0]          bus_owner
);

    localparam int CNT_W = tba_clog2(tba_max(HOLD_CYCLES, TURN_CYCLES) + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [OW-1:0]    pick_ptr, winner;
    logic             any_req, drive_last, turn_last, arb_now;

    function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] p);
        return (int'(p) >= N_SRC - 1) ? '0 : p + OW'(1);
    endfunction

    assign drive_last = (state_q == ST_DRIVE) && (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign turn_last  = (state_q == ST_TURN) && (cnt_q == CNT_W'(TURN_CYCLES - 1));
    // The final DRIVE/TURN edge doubles as the next arbitration edge, so
    // back-to-back ownership needs no extra IDLE cycle.
    assign arb_now    = (state_q == ST_IDLE) || turn_last ||
                        (drive_last && (TURN_CYCLES == 0));
    assign pick_ptr   = (state_q == ST_DRIVE) ? next_ptr(owner_q) : ptr_q;

    tristate_bus_arbiter_rr_priority_picker #(
        .N_SRC (N_SRC),
        .OW    (OW)
    ) u_rr_priority_picker (
        .req_i     (req),
        .ptr_i     (pick_ptr),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        grant_d = '0;
        case (state_q)
            ST_DRIVE: begin
                if (drive_last) begin
                    ptr_d   = next_ptr(owner_q);
                    cnt_d   = '0;
                    state_d = (TURN_CYCLES > 0) ? ST_TURN : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TURN: begin
                if (turn_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (arb_now && any_req) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            owner_d = winner;
            data_d  = data_in[winner*WIDTH +: WIDTH];
            grant_d = N_SRC'(1) << winner;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    assign grant     = grant_q;
    assign bus_valid = (state_q == ST_DRIVE);
    assign bus_owner = owner_q;
    assign bus       = bus_valid ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench: three arbiter instances with different hold/turn windows, each checked
// every cycle against a transaction-age reference model plus directed checks.
module tb_tristate_bus_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int OW = 2;
    localparam int NC = 3;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;
    logic chk_on;

    logic             rst_a     [NC];
    logic [N-1:0]     req_a     [NC];
    logic [N*W-1:0]   data_a    [NC];
    logic [N-1:0]     grant_a   [NC];
    logic [W-1:0]     bus_a     [NC];
    logic             valid_a   [NC];
    logic [OW-1:0]    owner_a   [NC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    for (genvar g = 0; g < NC; g++) begin : ch
        localparam int H = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        localparam int T = (g == 1) ? 0 : 1;

        wire [W-1:0] bus_w;
        pullup (bus_w);
        assign bus_a[g] = bus_w;

        tristate_bus_arbiter #(
            .WIDTH       (W),
            .N_SRC       (N),
            .HOLD_CYCLES (H),
            .TURN_CYCLES (T)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_a[g]),
            .req       (req_a[g]),
            .data_in   (data_a[g]),
            .grant     (grant_a[g]),
            .bus       (bus_w),
            .bus_valid (valid_a[g]),
            .bus_owner (owner_a[g])
        );

        // age = cycles since the last grant (0 = idle); a new owner may be
        // chosen whenever idle or once hold+turn cycles have elapsed.
        int         age = 0;
        int         m_ptr = 0;
        int         m_owner = 0;
        logic [W-1:0] m_data = '0;

        always @(posedge clk) begin
            if (!rst_a[g]) begin
                age     <= 0;
                m_ptr   <= 0;
                m_owner <= 0;
                m_data  <= '0;
            end else if ((age == 0 || age == H + T) && req_a[g] != 0) begin
                age     <= 1;
                m_owner <= rr_pick(req_a[g], m_ptr);
                m_data  <= data_a[g][rr_pick(req_a[g], m_ptr)*W +: W];
                m_ptr   <= (rr_pick(req_a[g], m_ptr) + 1) % N;
            end else if (age == 0 || age == H + T) begin
                age <= 0;
            end else begin
                age <= age + 1;
            end
        end

        always @(negedge clk) begin
            if (chk_on) begin
                check($sformatf("ch%0d_valid", g), 64'(valid_a[g]), 64'(age >= 1 && age <= H));
                check($sformatf("ch%0d_bus", g), 64'(bus_a[g]),
                      64'((age >= 1 && age <= H) ? m_data : {W{1'b1}}));
                check($sformatf("ch%0d_grant", g), 64'(grant_a[g]),
                      64'((age == 1) ? (N'(1) << m_owner) : N'(0)));
                check($sformatf("ch%0d_owner", g), 64'(owner_a[g]), 64'(m_owner));
            end
        end
    end

    task automatic wait_grant(input int c, input int bound, output int owner);
        int k;
        k = 0;
        owner = -1;
        while (k < bound && grant_a[c] == 0) begin
            @(negedge clk);
            k++;
        end
        if (grant_a[c] == 0) check($sformatf("ch%0d_grant_timeout", c), 64'(0), 64'(1));
        else owner = int'(owner_a[c]);
    endtask

    task automatic set_words(input int c, input logic [W-1:0] base);
        for (int i = 0; i < N; i++) data_a[c][i*W +: W] = base + W'(i);
    endtask

    int          own;
    logic [W-1:0] bus_seen [$];
    int          got_q [$];
    int          exp_q [$];

    initial begin
        chk_on = 1'b0;
        for (int c = 0; c < NC; c++) begin
            rst_a[c]  = 1'b0;
            req_a[c]  = '0;
            data_a[c] = '0;
        end
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        for (int c = 0; c < NC; c++) rst_a[c] = 1'b1;

        // Idle after reset: bus floats, nothing granted.
        repeat (10) begin
            @(negedge clk);
            check("idle_bus", 64'(bus_a[0]), 64'({W{1'b1}}));
            check("idle_owner", 64'(owner_a[0]), 64'(0));
        end

        // Single request from source 2.
        req_a[0] = 4'b0100;
        data_a[0][2*W +: W] = 32'hDEADBEEF;
        @(negedge clk);
        check("single_grant", 64'(grant_a[0]), 64'(4'b0100));
        check("single_bus", 64'(bus_a[0]), 64'(32'hDEADBEEF));
        check("single_owner", 64'(owner_a[0]), 64'(2));
        req_a[0] = '0;
        @(negedge clk);
        check("single_turn_z", 64'(bus_a[0]), 64'({W{1'b1}}));
        @(negedge clk);

        // Round-robin from a fresh pointer.
        rst_a[0] = 1'b0;
        @(negedge clk);
        rst_a[0] = 1'b1;
        req_a[0] = 4'b1111;
        set_words(0, 32'd1);
        repeat (10) begin
            @(negedge clk);
            if (grant_a[0] != 0) begin
                got_q.push_back(int'(owner_a[0]));
                bus_seen.push_back(bus_a[0]);
            end
        end
        req_a[0] = '0;
        exp_q = '{0, 1, 2, 3, 0};
        check("rr_grant_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("rr_order_%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
            check($sformatf("rr_bus_%0d", i), 64'(bus_seen[i]), 64'(exp_q[i] + 1));
        end

        // Wrap-around: serve source 2, then 3 must beat 0.
        @(negedge clk);
        req_a[0] = 4'b0100;
        wait_grant(0, 10, own);
        check("wrap_first", 64'(own), 64'(2));
        req_a[0] = 4'b1001;
        @(negedge clk);
        wait_grant(0, 10, own);
        check("wrap_src3", 64'(own), 64'(3));
        @(negedge clk);
        wait_grant(0, 10, own);
        check("wrap_src0", 64'(own), 64'(0));
        req_a[0] = '0;

        // Long hold, no turnaround: back-to-back grants without a float gap.
        req_a[1] = 4'b0010;
        data_a[1][1*W +: W] = 32'h12345678;
        wait_grant(1, 10, own);
        check("sweep_owner", 64'(own), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("sweep_valid_%0d", i), 64'(valid_a[1]), 64'(1));
            check($sformatf("sweep_grant_%0d", i), 64'(grant_a[1]), 64'((i == 2) ? 4'b0010 : 4'b0000));
        end
        req_a[1] = '0;

        // Reset in the second drive cycle of a later grant.
        req_a[2] = 4'b1111;
        set_words(2, 32'hA0);
        wait_grant(2, 10, own);
        @(negedge clk);
        wait_grant(2, 20, own);
        check("mid_owner_before", 64'(own), 64'(1));
        @(negedge clk);
        rst_a[2] = 1'b0;
        @(negedge clk);
        check("mid_valid", 64'(valid_a[2]), 64'(0));
        check("mid_grant", 64'(grant_a[2]), 64'(0));
        check("mid_bus", 64'(bus_a[2]), 64'({W{1'b1}}));
        rst_a[2] = 1'b1;
        wait_grant(2, 10, own);
        check("mid_after_owner", 64'(own), 64'(0));
        req_a[2] = '0;

        // Random traffic with occasional resets on every instance.
        repeat (400) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 3) == 0) req_a[c] = N'($urandom_range(0, 15));
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 1) == 1) data_a[c][i*W +: W] = $urandom;
                end
                rst_a[c] = ($urandom_range(0, 79) != 0);
            end
        end
        for (int c = 0; c < NC; c++) begin
            req_a[c] = '0;
            rst_a[c] = 1'b1;
        end
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
